tri_mem_responder: RTL and testbench
====================================

# tri_mem_responder

Memory-side responder for the triangle fetch handshake used by the ray-triangle intersection pipeline. Holds up to NUM_TRIANGLE triangles written by the host loader. Serves them one per request, in index order, as {v0, v1, v2, sid} with a one-cycle Mem_Rdy pulse. A sid of zero terminates the list.

## Interface
- NUM_TRIANGLE, 512: triangle capacity; BIT_TRIANGLE = $clog2(NUM_TRIANGLE).
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- Mem_En  input  1  fetch request from the triangle manager; level, may be held while waiting.
- clear  input  1  synchronous; rewinds the read pointer to 0 and drops any outstanding read.
- Mem_Rdy  output  1  one-cycle pulse; v*_out/sid_out valid in that cycle.
- Mem_NotValid  output  1  high when no complete triangle list is loaded (EMPTY/LOAD).
- v0_out, v1_out, v2_out  output  96 each  vertex data {x,y,z} fp32.
- sid_out  output  32  shader id; 0 = end of list.
- load_start  input  1  pulse; begins a new load, invalidates the list.
- wr_en  input  1  host write strobe (honoured in LOAD only).
- wr_addr  input  BIT_TRIANGLE  triangle index.
- wr_v0, wr_v1, wr_v2  input  96 each  vertex write data.
- wr_sid  input  32  shader id write data.
- load_done  input  1  pulse; list complete, responder becomes ready.

## Operation
- States: EMPTY, LOAD, READY, BUSY.
  - EMPTY: reset state.
  - EMPTY/READY/BUSY -> LOAD on load_start.
  - LOAD -> READY on load_done.
  - READY -> BUSY on Mem_En.
  - BUSY -> READY when the response issues.
- Mem_NotValid = 1 in EMPTY and LOAD, 0 in READY and BUSY.
- Read pointer and count:
  - rd_ptr is BIT_TRIANGLE+1 bits.
  - tri_count is BIT_TRIANGLE+1 bits. It is cleared on load_start.
  - Each LOAD write sets tri_count = max(tri_count, wr_addr+1).
- Request acceptance:
  - Mem_En is accepted only in READY. A held Mem_En is not re-accepted until BUSY returns to READY.
  - Mem_En in EMPTY, LOAD or BUSY is ignored.
- Accepted request, rd_ptr < tri_count: return mem[rd_ptr] as stored, then rd_ptr += 1.
- Accepted request, rd_ptr == tri_count: return the terminator (all data 0, sid 0). rd_ptr does not advance, so repeated requests keep returning the terminator.
- A stored sid of 0 is returned as-is and acts as an early terminator for the consumer.
- Output hold: v*_out/sid_out hold the last response until the next response, clear, load_start or rst.
- Simultaneous events:
  - clear + Mem_En: clear wins and the request is dropped.
  - clear in BUSY: no Mem_Rdy; return to READY.
  - clear in LOAD/EMPTY: rewinds rd_ptr only; state unchanged.
  - load_start in BUSY: the read is aborted and there is no Mem_Rdy.
  - wr_en + load_done in the same cycle: the write is performed and counted.
  - load_start + load_done: load_start wins.
  - wr_en outside LOAD: ignored.

## Timing
- Fixed latency: Mem_En sampled high in READY at edge T. Mem_Rdy = 1 for exactly the cycle following edge T+2; data is valid in the same cycle.
- Requests are non-overlapping; the earliest next acceptance is edge T+3.
- Host writes complete in one cycle. A write at edge T is readable by a request accepted at edge T+1 or later (after load_done).
- Reset values:
  - Mem_Rdy = 0, Mem_NotValid = 1, all data outputs = 0.
  - state = EMPTY, rd_ptr = 0, tri_count = 0.
  - RAM contents are undefined.
- Reset mid-read: no Mem_Rdy is issued.

## Configuration
- TRI_RESP_STATS_EN defined:
  - Adds output req_count (32 bits, reset 0).
  - req_count increments on every issued Mem_Rdy, terminators included.
  - Cleared on load_start; not cleared by clear.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package tri_pkg holds:
  - the NUM_TRIANGLE default;
  - tri_t packed struct {v0, v1, v2: 96 bits; sid: 32 bits} = 320 bits;
  - the state enum {EMPTY, LOAD, READY, BUSY};
  - the TERMINATOR constant, all zero.
- Sub-module tri_ram: simple dual-port synchronous RAM, NUM_TRIANGLE x 320 bits.
  - One write port.
  - One read port with a registered address and registered output; this provides the 2-cycle latency.
- Top level holds the FSM, rd_ptr, tri_count, the terminator mux and the output registers.

## Test plan
- Reset, then hold Mem_En = 1 with no load -> Mem_NotValid = 1 and Mem_Rdy never asserts.
- Load 3 triangles (sid 5, 6, 7 at addr 0..2) + load_done, then 4 handshakes -> sids 5, 6, 7, 0. Each Mem_Rdy occurs exactly 2 cycles after acceptance.
- Hold Mem_En high continuously after a 2-entry load -> exactly one pulse per 3 cycles, no duplicate or skipped index.
- After reading entry 1, pulse clear together with Mem_En -> no Mem_Rdy; the next request returns entry 0.
- Pulse load_start while BUSY -> no Mem_Rdy, Mem_NotValid = 1 next cycle, tri_count = 0.
- Write addr 9 only, then load_done -> ten responses (entries 0..9, unwritten entries undefined), then the terminator with sid 0. With TRI_RESP_STATS_EN, req_count = 11.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle fetch responder.
package tri_pkg;

  localparam int unsigned NUM_TRIANGLE_DEF = 512;
  localparam int unsigned VERT_W           = 96;
  localparam int unsigned SID_W            = 32;

  typedef struct packed {
    logic [VERT_W-1:0] v0;
    logic [VERT_W-1:0] v1;
    logic [VERT_W-1:0] v2;
    logic [SID_W-1:0]  sid;
  } tri_t;

  localparam int unsigned TRI_W = $bits(tri_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    BUSY  = 2'd3
  } state_t;

  localparam tri_t TERMINATOR = '0;

endpackage

// File: rtl/tri_ram.sv
// Simple dual-port triangle store: one write port, one read port with
// registered address and registered data (two-cycle read latency).
module tri_ram
  import tri_pkg::*;
#(
  parameter  int unsigned DEPTH = NUM_TRIANGLE_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  tri_t          wdata,
  input  logic [AW-1:0] raddr,
  output tri_t          rdata
);

  tri_t          mem [DEPTH];
  logic [AW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    raddr_q <= raddr;
    rdata   <= mem[raddr_q];
  end

endmodule

// File: rtl/tri_mem_responder.sv
// Triangle fetch responder: host-loaded triangle list served one per request.
// Optional `TRI_RESP_STATS_EN adds the req_count output.
module tri_mem_responder
  import tri_pkg::*;
#(
  parameter  int unsigned NUM_TRIANGLE = NUM_TRIANGLE_DEF,
  localparam int unsigned BIT_TRIANGLE = $clog2(NUM_TRIANGLE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Mem_En,
  input  logic                    clear,
  output logic                    Mem_Rdy,
  output logic                    Mem_NotValid,
  output logic [VERT_W-1:0]       v0_out,
  output logic [VERT_W-1:0]       v1_out,
  output logic [VERT_W-1:0]       v2_out,
  output logic [SID_W-1:0]        sid_out,
  input  logic                    load_start,
  input  logic                    wr_en,
  input  logic [BIT_TRIANGLE-1:0] wr_addr,
  input  logic [VERT_W-1:0]       wr_v0,
  input  logic [VERT_W-1:0]       wr_v1,
  input  logic [VERT_W-1:0]       wr_v2,
  input  logic [SID_W-1:0]        wr_sid,
  input  logic                    load_done
`ifdef TRI_RESP_STATS_EN
  ,
  output logic [31:0]             req_count
`endif
);

  localparam int unsigned PTR_W = BIT_TRIANGLE + 1;

  state_t             state_q, state_nxt;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   tri_count_q;
  logic               req_q1, req_q2;
  logic               term_q1, term_q2;
  tri_t               resp_q;
  tri_t               ram_rdata;
  tri_t               wr_data;

  logic               accept_c;
  logic               issue_c;
  logic               wr_fire_c;
  logic               term_c;
  logic [PTR_W-1:0]   wr_cnt_c;

  assign wr_data  = '{v0: wr_v0, v1: wr_v1, v2: wr_v2, sid: wr_sid};
  assign term_c   = (rd_ptr_q >= tri_count_q);
  assign wr_cnt_c = {1'b0, wr_addr} + PTR_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; load_start dominates every other event
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      EMPTY: if (load_start) state_nxt = LOAD;
      LOAD: begin
        if (load_start)     state_nxt = LOAD;
        else if (load_done) state_nxt = READY;
      end
      READY: begin
        if (load_start)    state_nxt = LOAD;
        else if (accept_c) state_nxt = BUSY;
      end
      BUSY: begin
        if (load_start)  state_nxt = LOAD;
        else if (clear)  state_nxt = READY;
        else if (req_q2) state_nxt = READY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Control strobes derived from the current state
  always_comb begin
    accept_c  = 1'b0;
    issue_c   = 1'b0;
    wr_fire_c = 1'b0;
    if (state_q == READY && Mem_En && !clear && !load_start) accept_c = 1'b1;
    if (state_q == BUSY && req_q2 && !clear && !load_start)  issue_c  = 1'b1;
    if (state_q == LOAD && wr_en && !load_start)             wr_fire_c = 1'b1;
  end

  tri_ram #(.DEPTH(NUM_TRIANGLE)) u_ram (
    .clk   (clk),
    .we    (wr_fire_c),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_ptr_q[BIT_TRIANGLE-1:0]),
    .rdata (ram_rdata)
  );

  // Read pointer and list length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      tri_count_q <= '0;
    end else begin
      if (clear || load_start) begin
        rd_ptr_q <= '0;
      end else if (accept_c && !term_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (load_start) begin
        tri_count_q <= '0;
      end else if (wr_fire_c && (wr_cnt_c > tri_count_q)) begin
        tri_count_q <= wr_cnt_c;
      end
    end
  end

  // Request pipeline tracking the RAM latency; clear/load_start abort it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q1  <= 1'b0;
      req_q2  <= 1'b0;
      term_q1 <= 1'b0;
      term_q2 <= 1'b0;
    end else begin
      req_q1  <= accept_c;
      req_q2  <= req_q1 && !clear && !load_start;
      term_q1 <= term_c;
      term_q2 <= term_q1;
    end
  end

  // Response and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Mem_Rdy      <= 1'b0;
      Mem_NotValid <= 1'b1;
      resp_q       <= TERMINATOR;
    end else begin
      Mem_Rdy      <= issue_c;
      Mem_NotValid <= (state_nxt == EMPTY) || (state_nxt == LOAD);
      if (clear || load_start) begin
        resp_q <= TERMINATOR;
      end else if (issue_c) begin
        resp_q <= term_q2 ? TERMINATOR : ram_rdata;
      end
    end
  end

  assign v0_out  = resp_q.v0;
  assign v1_out  = resp_q.v1;
  assign v2_out  = resp_q.v2;
  assign sid_out = resp_q.sid;

`ifdef TRI_RESP_STATS_EN
  // Issued-response counter, terminators included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_count <= '0;
    end else if (load_start) begin
      req_count <= '0;
    end else if (issue_c) begin
      req_count <= req_count + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tri_mem_responder.sv
// Scoreboard bench for tri_mem_responder: expected responses are queued at
// request time and compared when Mem_Rdy pulses.
module tb_tri_mem_responder;
  import tri_pkg::*;

  localparam int unsigned NT = NUM_TRIANGLE_DEF;
  localparam int unsigned BT = $clog2(NT);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              Mem_En = 1'b0;
  logic              clear = 1'b0;
  logic              Mem_Rdy;
  logic              Mem_NotValid;
  logic [VERT_W-1:0] v0_out, v1_out, v2_out;
  logic [SID_W-1:0]  sid_out;
  logic              load_start = 1'b0;
  logic              wr_en = 1'b0;
  logic [BT-1:0]     wr_addr = '0;
  logic [VERT_W-1:0] wr_v0 = '0, wr_v1 = '0, wr_v2 = '0;
  logic [SID_W-1:0]  wr_sid = '0;
  logic              load_done = 1'b0;
`ifdef TRI_RESP_STATS_EN
  logic [31:0]       req_count;
`endif

  tri_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .Mem_En       (Mem_En),
    .clear        (clear),
    .Mem_Rdy      (Mem_Rdy),
    .Mem_NotValid (Mem_NotValid),
    .v0_out       (v0_out),
    .v1_out       (v1_out),
    .v2_out       (v2_out),
    .sid_out      (sid_out),
    .load_start   (load_start),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_v0        (wr_v0),
    .wr_v1        (wr_v1),
    .wr_v2        (wr_v2),
    .wr_sid       (wr_sid),
    .load_done    (load_done)
`ifdef TRI_RESP_STATS_EN
    ,
    .req_count    (req_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    tri_t d;
    int   cyc;
    bit   dc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  tri_t mem_m [NT];
  bit   valid_m [NT];
  int   rd_ptr_m = 0;
  int   count_m = 0;
  int   req_m = 0;
  int   cyc = 0;
  int   rdy_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [TRI_W-1:0] got, input logic [TRI_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && Mem_Rdy) begin
      rdy_cnt++;
      if (q.size() == 0) begin
        check("spurious_rdy", TRI_W'(1), TRI_W'(0));
      end else begin
        e = q.pop_front();
        check("rdy_cycle", TRI_W'(cyc), TRI_W'(e.cyc));
        if (!e.dc) check("rsp_data", {v0_out, v1_out, v2_out, sid_out}, e.d);
      end
    end
  end

  // Queue the response the model expects for one accepted request
  task automatic push_exp(input int rdy_cyc);
    exp_t x;
    x.cyc = rdy_cyc;
    if (rd_ptr_m < count_m) begin
      x.d  = mem_m[rd_ptr_m];
      x.dc = !valid_m[rd_ptr_m];
      rd_ptr_m++;
    end else begin
      x.d  = TERMINATOR;
      x.dc = 1'b0;
    end
    req_m++;
    q.push_back(x);
  endtask

  task automatic do_load_start();
    @(posedge clk); #1;
    load_start = 1'b1;
    count_m = 0;
    rd_ptr_m = 0;
    req_m = 0;
    for (int i = 0; i < int'(NT); i++) valid_m[i] = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic do_load_done();
    @(posedge clk); #1;
    load_done = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] sid, input bit done, input bit in_load);
    tri_t d;
    @(posedge clk); #1;
    d.v0 = {$urandom(), $urandom(), $urandom()};
    d.v1 = {$urandom(), $urandom(), $urandom()};
    d.v2 = {$urandom(), $urandom(), $urandom()};
    d.sid = sid;
    wr_en = 1'b1; wr_addr = BT'(a); load_done = done;
    wr_v0 = d.v0; wr_v1 = d.v1; wr_v2 = d.v2; wr_sid = d.sid;
    if (in_load) begin
      mem_m[a] = d;
      valid_m[a] = 1'b1;
      if (a + 1 > count_m) count_m = a + 1;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; load_done = 1'b0;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1;
    Mem_En = 1'b1;
    push_exp(cyc + 3);
    @(posedge clk); #1;
    Mem_En = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", TRI_W'(q.size()), TRI_W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", TRI_W'(Mem_Rdy), TRI_W'(0));
    check("rst_notvalid", TRI_W'(Mem_NotValid), TRI_W'(1));
    check("rst_data", {v0_out, v1_out, v2_out, sid_out}, TRI_W'(0));
    #1 rst = 1'b0;

    // No list loaded: held request must be ignored
    @(posedge clk); #1;
    Mem_En = 1'b1;
    repeat (10) @(posedge clk);
    #1 Mem_En = 1'b0;
    @(negedge clk);
    check("empty_notvalid", TRI_W'(Mem_NotValid), TRI_W'(1));
    check("empty_no_rdy", TRI_W'(rdy_cnt), TRI_W'(0));

    // Three triangles, then four handshakes; a write outside LOAD is ignored
    do_load_start();
    @(negedge clk);
    check("load_notvalid", TRI_W'(Mem_NotValid), TRI_W'(1));
    wr(0, 32'd5, 1'b0, 1'b1);
    wr(1, 32'd6, 1'b0, 1'b1);
    wr(2, 32'd7, 1'b0, 1'b1);
    do_load_done();
    @(negedge clk);
    check("ready_notvalid", TRI_W'(Mem_NotValid), TRI_W'(0));
    wr(3, 32'd88, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse_req();
      wait_drain();
    end
    check("term_sid", TRI_W'(sid_out), TRI_W'(0));

    // Held Mem_En: one pulse per three cycles
    do_load_start();
    wr(0, 32'd11, 1'b0, 1'b1);
    wr(1, 32'd12, 1'b0, 1'b1);
    do_load_done();
    @(posedge clk); #1;
    snap = rdy_cnt;
    Mem_En = 1'b1;
    n = cyc;
    push_exp(n + 3);
    push_exp(n + 6);
    push_exp(n + 9);
    repeat (7) @(posedge clk);
    #1 Mem_En = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    check("held_pulses", TRI_W'(rdy_cnt - snap), TRI_W'(3));

    // clear together with Mem_En drops the request and rewinds
    do_load_start();
    wr(0, 32'd5, 1'b0, 1'b1);
    wr(1, 32'd6, 1'b0, 1'b1);
    wr(2, 32'd7, 1'b0, 1'b1);
    do_load_done();
    pulse_req(); wait_drain();
    pulse_req(); wait_drain();
    @(posedge clk); #1;
    snap = rdy_cnt;
    Mem_En = 1'b1; clear = 1'b1;
    rd_ptr_m = 0;
    @(posedge clk); #1;
    Mem_En = 1'b0; clear = 1'b0;
    repeat (5) @(negedge clk);
    check("clear_no_rdy", TRI_W'(rdy_cnt - snap), TRI_W'(0));
    check("clear_zero", TRI_W'(sid_out), TRI_W'(0));
    pulse_req(); wait_drain();

    // load_start while BUSY aborts the read and empties the list
    @(posedge clk); #1;
    snap = rdy_cnt;
    Mem_En = 1'b1;
    @(posedge clk); #1;
    Mem_En = 1'b0; load_start = 1'b1;
    count_m = 0; rd_ptr_m = 0; req_m = 0;
    for (int i = 0; i < int'(NT); i++) valid_m[i] = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    check("abort_notvalid", TRI_W'(Mem_NotValid), TRI_W'(1));
    repeat (5) @(negedge clk);
    check("abort_no_rdy", TRI_W'(rdy_cnt - snap), TRI_W'(0));
`ifdef TRI_RESP_STATS_EN
    check("abort_req_count", TRI_W'(req_count), TRI_W'(req_m));
`endif
    do_load_done();
    pulse_req(); wait_drain();

    // Sparse load: only addr 9, written together with load_done
    do_load_start();
    wr(9, 32'd99, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      pulse_req();
      wait_drain();
    end
    check("sparse_term_sid", TRI_W'(sid_out), TRI_W'(0));
`ifdef TRI_RESP_STATS_EN
    check("req_count", TRI_W'(req_count), TRI_W'(req_m));
`endif

    // Reset mid-read issues nothing
    @(posedge clk); #1;
    snap = rdy_cnt;
    Mem_En = 1'b1;
    @(posedge clk); #1;
    Mem_En = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_rdy", TRI_W'(rdy_cnt - snap), TRI_W'(0));
    check("rst_mid_notvalid", TRI_W'(Mem_NotValid), TRI_W'(1));
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
